hazard_scoreboard: RTL and testbench

- Register-file scoreboard and issue controller for the pipelined core.
- Tracks every register with a write in flight between ID and WB (regfile write), and holds the ID stage while an instruction reads such a register.
- Sits beside the ID stage: it sees the decoded rs/rt/rd and write_en, and drives the stall that freezes PC, instruction fetch and the ID/EXE bubble insert.

---
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register-file scoreboard and issue controller beside the ID stage.
// Each register has a down-counter that is loaded with WB_LAT when a writer
// issues and counts down to zero on the edge where the regfile write lands.
// A reader of a register whose counter is still running holds the ID stage.
// Optional build macro: SCOREBOARD_BYPASS_EN (write-through regfile, so a
// consumer may fire once the counter has reached 1).
module hazard_scoreboard #(
  parameter int ASIZE  = 4,
  parameter int WB_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic                    issue_wen,
  input  logic [ASIZE-1:0]        issue_waddr,
  input  logic                    src1_use,
  input  logic [ASIZE-1:0]        src1_addr,
  input  logic                    src2_use,
  input  logic [ASIZE-1:0]        src2_addr,
  input  logic                    flush,
  output logic                    stall,
  output logic                    issue_fire,
  output logic [(1<<ASIZE)-1:0]   busy_mask,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int NREG = 1 << ASIZE;
  localparam int CW   = $clog2(WB_LAT + 1);
  localparam logic [CW-1:0] LAT_INIT = CW'(WB_LAT);

  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] haz_busy;
  logic            hazard1;
  logic            hazard2;
  logic            record;

  // Hazard detection looks only at the current counter state, so an
  // instruction reading its own destination never waits on itself.
  assign hazard1    = src1_use & haz_busy[src1_addr];
  assign hazard2    = src2_use & haz_busy[src2_addr];
  assign stall      = issue_valid & (hazard1 | hazard2) & ~flush;
  assign issue_fire = issue_valid & ~stall;
  // A flushed instruction is discarded, so its write is never tracked.
  assign record     = issue_fire & issue_wen & ~flush;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;

      // Counter update: flush clears, an issuing writer reloads (also on
      // WAW), otherwise a running counter steps toward zero.
      always_comb begin
        cnt_next = '0;
        if (flush) begin
          cnt_next = '0;
        end else if (record && (issue_waddr == ASIZE'(gi))) begin
          cnt_next = LAT_INIT;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      // Counter state register.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign busy_next[gi] = (cnt_next != '0);

`ifdef SCOREBOARD_BYPASS_EN
      // Write-through regfile: the last counting cycle can already forward.
      assign haz_busy[gi] = (cnt_reg > CW'(1));
`else
      assign haz_busy[gi] = (cnt_reg != '0);
`endif
    end
  endgenerate

  // Registered pending-write mask, always equal to (counter != 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= busy_next;
    end
  end

  // Saturating count of stalled cycles; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a table of directed RAW vectors,
// hand-written multi-cycle sequences and randomized traffic, all compared
// against a timestamp-based model (a register is pending while fewer than
// WB_LAT edges have passed since its writer's issue edge).
module tb_hazard_scoreboard;

  localparam int ASIZE  = 4;
  localparam int WB_LAT = 4;
  localparam int CNT_W  = 16;
  localparam int NREG   = 1 << ASIZE;
  localparam int NONE   = -1000000;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic             issue_wen;
  logic [ASIZE-1:0] issue_waddr;
  logic             src1_use;
  logic [ASIZE-1:0] src1_addr;
  logic             src2_use;
  logic [ASIZE-1:0] src2_addr;
  logic             flush;
  logic             stall;
  logic             issue_fire;
  logic [NREG-1:0]  busy_mask;
  logic [CNT_W-1:0] stall_cnt;

  hazard_scoreboard #(.ASIZE(ASIZE), .WB_LAT(WB_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_waddr(issue_waddr), .src1_use(src1_use), .src1_addr(src1_addr),
    .src2_use(src2_use), .src2_addr(src2_addr), .flush(flush),
    .stall(stall), .issue_fire(issue_fire), .busy_mask(busy_mask),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int txn = 0;
  int issue_edge [NREG];
  int m_stall_cnt = 0;

  logic            smp_stall;
  logic            smp_fire;
  logic [NREG-1:0] smp_busy;
  logic [CNT_W-1:0] smp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", name, act, exp, txn);
    end
  endtask

  // One clock cycle: drive inputs, sample and compare before the edge,
  // then advance the model across the edge.
  task automatic step(input logic r, input logic v, input logic w, input logic [3:0] wa,
                      input logic u1, input logic [3:0] a1, input logic u2,
                      input logic [3:0] a2, input logic f, input bit chk);
    logic [NREG-1:0] m_busy;
    logic [NREG-1:0] m_haz;
    logic m_stall, m_fire;
    int age;
    rst = r; issue_valid = v; issue_wen = w; issue_waddr = wa;
    src1_use = u1; src1_addr = a1; src2_use = u2; src2_addr = a2; flush = f;
    for (int i = 0; i < NREG; i++) begin
      age = cyc - issue_edge[i];
      m_busy[i] = (age >= 1) && (age <= WB_LAT);
`ifdef SCOREBOARD_BYPASS_EN
      m_haz[i] = (age >= 1) && (age <= WB_LAT - 1);
`else
      m_haz[i] = m_busy[i];
`endif
    end
    m_stall = v & ((u1 & m_haz[a1]) | (u2 & m_haz[a2])) & ~f;
    m_fire  = v & ~m_stall;
    @(negedge clk);
    smp_stall = stall; smp_fire = issue_fire; smp_busy = busy_mask; smp_cnt = stall_cnt;
    $display("txn %0d rst=%0b v=%0b w=%0b wa=%0d s1=%0b/%0d s2=%0b/%0d fl=%0b -> stall=%0b fire=%0b busy=%h cnt=%0d",
             txn, r, v, w, wa, u1, a1, u2, a2, f, smp_stall, smp_fire, smp_busy, smp_cnt);
    if (chk) begin
      check("model_stall", {31'd0, smp_stall}, {31'd0, m_stall});
      check("model_fire", {31'd0, smp_fire}, {31'd0, m_fire});
      check("model_busy", {16'd0, smp_busy}, {16'd0, m_busy});
      check("model_stall_cnt", {16'd0, smp_cnt}, m_stall_cnt);
    end
    if (r) begin
      for (int i = 0; i < NREG; i++) issue_edge[i] = NONE;
      m_stall_cnt = 0;
    end else begin
      if (f) begin
        for (int i = 0; i < NREG; i++) issue_edge[i] = NONE;
      end else if (m_fire && w) begin
        issue_edge[wa] = cyc;
      end
      if (m_stall && m_stall_cnt < 65535) m_stall_cnt++;
    end
    cyc++;
    txn++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic v, w; logic [3:0] wa;
    logic u1; logic [3:0] a1;
    logic u2; logic [3:0] a2;
    logic f;
    logic e_stall, e_fire;
    logic [15:0] e_busy;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(logic v, logic w, logic [3:0] wa, logic u1, logic [3:0] a1,
                              logic e_stall, logic e_fire, logic [15:0] e_busy);
    vec_t t;
    t.v = v; t.w = w; t.wa = wa; t.u1 = u1; t.a1 = a1;
    t.u2 = 1'b0; t.a2 = 4'd0; t.f = 1'b0;
    t.e_stall = e_stall; t.e_fire = e_fire; t.e_busy = e_busy;
    return t;
  endfunction

  initial begin
    int ones;
    int cnt_after;
    for (int i = 0; i < NREG; i++) issue_edge[i] = NONE;
    rst = 1'b1; issue_valid = 1'b0; issue_wen = 1'b0; issue_waddr = '0;
    src1_use = 1'b0; src1_addr = '0; src2_use = 1'b0; src2_addr = '0; flush = 1'b0;
    @(posedge clk); #1;

    // Reset with random inputs for two cycles.
    step(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
         1'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    step(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
         1'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    idle();
    check("reset_busy", {16'd0, smp_busy}, 32'd0);
    check("reset_stall_cnt", {16'd0, smp_cnt}, 32'd0);
    check("reset_stall", {31'd0, smp_stall}, 32'd0);

    // RAW table: producer writes r3, one idle cycle, then a reader of r3.
    tbl[0] = mk(1, 1, 4'd3, 0, 4'd0, 0, 1, 16'h0000);
    tbl[1] = mk(0, 0, 4'd0, 0, 4'd0, 0, 0, 16'h0008);
    tbl[2] = mk(1, 0, 4'd0, 1, 4'd3, 1, 0, 16'h0008);
    tbl[3] = mk(1, 0, 4'd0, 1, 4'd3, 1, 0, 16'h0008);
`ifdef SCOREBOARD_BYPASS_EN
    tbl[4] = mk(1, 0, 4'd0, 1, 4'd3, 0, 1, 16'h0008);
`else
    tbl[4] = mk(1, 0, 4'd0, 1, 4'd3, 1, 0, 16'h0008);
`endif
    tbl[5] = mk(1, 0, 4'd0, 1, 4'd3, 0, 1, 16'h0000);
    cnt_after = int'(smp_cnt);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, tbl[k].v, tbl[k].w, tbl[k].wa, tbl[k].u1, tbl[k].a1,
           tbl[k].u2, tbl[k].a2, tbl[k].f, 1'b1);
      check("tbl_stall", {31'd0, smp_stall}, {31'd0, tbl[k].e_stall});
      check("tbl_fire", {31'd0, smp_fire}, {31'd0, tbl[k].e_fire});
      check("tbl_busy", {16'd0, smp_busy}, {16'd0, tbl[k].e_busy});
    end
`ifdef SCOREBOARD_BYPASS_EN
    check("raw_stall_cnt", {16'd0, smp_cnt} - cnt_after, 32'd2);
`else
    check("raw_stall_cnt", {16'd0, smp_cnt} - cnt_after, 32'd3);
`endif

    // WAW reload of r5: busy must last WB_LAT cycles after the second issue.
    step(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle();
    step(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("waw_busy_before_reload", {31'd0, smp_busy[5]}, 32'd1);
    ones = 0;
    for (int k = 0; k < 20; k++) begin
      idle();
      if (!smp_busy[5]) break;
      ones++;
    end
    check("waw_busy_cycles", ones, WB_LAT);

    // Flush with r2/r7 pending and an issue writing r9 that reads r2.
    step(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b1);
    check("flush_pending_before", {16'd0, smp_busy & 16'h0084}, 32'h0084);
    check("flush_stall", {31'd0, smp_stall}, 32'd0);
    idle();
    check("flush_busy_after", {16'd0, smp_busy}, 32'd0);

    // Unused source pointing at busy r4, then self-dependency on idle r6.
    step(1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b0, 1'b1);
    check("unused_src_stall", {31'd0, smp_stall}, 32'd0);
    check("unused_src_fire", {31'd0, smp_fire}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 1'b1);
    check("selfdep_fire", {31'd0, smp_fire}, 32'd1);
    idle();
    check("selfdep_busy", {31'd0, smp_busy[6]}, 32'd1);

    // Reset in the middle of pending writes.
    step(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 1'b1, 4'd6, 1'b0, 1'b1);
    check("midreset_busy", {16'd0, smp_busy}, 32'd0);
    check("midreset_stall", {31'd0, smp_stall}, 32'd0);
    check("midreset_stall_cnt", {16'd0, smp_cnt}, 32'd0);

    // Randomized traffic on a narrow address range to provoke hazards.
    for (int k = 0; k < 1200; k++) begin
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 6),
           4'($urandom_range(0, 7)),
           1'($urandom), 4'($urandom_range(0, 7)),
           1'($urandom), 4'($urandom_range(0, 7)),
           ($urandom_range(0, 19) == 0),
           1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
